// File: rtl/mac_operand_feeder.sv
// Operand feeder for a MAC unit: a 4-deep operand-pair FIFO drained by a small
// batch FSM that also captures accumulator results on update strobes.
module mac_operand_feeder (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic [4:0]  wr_multiplicand_i,
    input  logic [4:0]  wr_multiplier_i,
    input  logic        start_i,
    input  logic [3:0]  batch_len_i,
    input  logic        fetching_input_i,
    input  logic        updating_acc_result_i,
    input  logic [15:0] mac_result_i,
    output logic [4:0]  multiplicand_o,
    output logic [4:0]  multiplier_o,
    output logic [15:0] result_o,
    output logic        result_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        underrun_o,
    output logic [2:0]  fifo_level_o
);

    typedef enum logic [1:0] {IDLE, FEED, WAIT_RES, DONE} state_t;

    state_t      state, state_nxt;
    logic [9:0]  mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  level;
    logic [3:0]  issue_cnt, res_cnt, res_cnt_nxt;
    logic        upd_q;
    logic        fifo_empty, push, pop, fetch_empty, rise, capture, start_ok;

    assign fifo_empty  = (level == 3'd0);
    assign wr_ready_o  = (level < 3'd4);
    assign push        = wr_valid_i && wr_ready_o;
    assign pop         = (state == FEED) && fetching_input_i && !fifo_empty;
    assign fetch_empty = (state == FEED) && fetching_input_i && fifo_empty;
    assign rise        = updating_acc_result_i && !upd_q;
    assign capture     = rise && ((state == FEED) || (state == WAIT_RES));
    assign start_ok    = (state == IDLE) && start_i && (batch_len_i != 4'd0);
    assign res_cnt_nxt = (capture && (res_cnt != 4'd0)) ? res_cnt - 4'd1 : res_cnt;

    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);
    assign fifo_level_o = level;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_nxt = state;
        case (state)
            IDLE:     if (start_ok) state_nxt = FEED;
            FEED:     if (pop && (issue_cnt == 4'd1)) state_nxt = WAIT_RES;
            WAIT_RES: if (res_cnt_nxt == 4'd0) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Operands come straight off the FIFO head, so a push into an empty FIFO shows up a cycle later.
    always_comb begin
        {multiplicand_o, multiplier_o} = 10'd0;
        if ((state == FEED) && !fifo_empty)
            {multiplicand_o, multiplier_o} = mem[rd_ptr];
    end

    // NOTE: the storage array is deliberately not reset; the pointers and level make stale data unreachable.
    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= {wr_multiplicand_i, wr_multiplier_i};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state          <= IDLE;
            wr_ptr         <= 2'd0;
            rd_ptr         <= 2'd0;
            level          <= 3'd0;
            issue_cnt      <= 4'd0;
            res_cnt        <= 4'd0;
            result_o       <= 16'd0;
            result_valid_o <= 1'b0;
            underrun_o     <= 1'b0;
            upd_q          <= 1'b0;
        end else begin
            state          <= state_nxt;
            upd_q          <= updating_acc_result_i;
            result_valid_o <= capture;
            if (capture)
                result_o <= mac_result_i;

            if (start_ok) begin
                issue_cnt  <= batch_len_i;
                res_cnt    <= batch_len_i;
                underrun_o <= 1'b0;
            end else begin
                res_cnt <= res_cnt_nxt;
                if (pop)
                    issue_cnt <= issue_cnt - 4'd1;
                if (fetch_empty)
                    underrun_o <= 1'b1;
            end

            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            // A push while full is already excluded by wr_ready_o, even when a pop coincides.
            case ({push, pop})
                2'b10:   level <= level + 3'd1;
                2'b01:   level <= level - 3'd1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder: directed batch scenarios followed by
// randomized traffic, all compared each cycle against a queue-based reference model.
module tb_mac_operand_feeder;

    logic        clk_i = 1'b0;
    logic        reset_i, wr_valid_i, wr_ready_o, start_i;
    logic [4:0]  wr_multiplicand_i, wr_multiplier_i, multiplicand_o, multiplier_o;
    logic [3:0]  batch_len_i;
    logic        fetching_input_i, updating_acc_result_i;
    logic [15:0] mac_result_i, result_o;
    logic        result_valid_o, busy_o, done_o, underrun_o;
    logic [2:0]  fifo_level_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    mac_operand_feeder dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_multiplicand_i(wr_multiplicand_i), .wr_multiplier_i(wr_multiplier_i),
        .start_i(start_i), .batch_len_i(batch_len_i),
        .fetching_input_i(fetching_input_i), .updating_acc_result_i(updating_acc_result_i),
        .mac_result_i(mac_result_i),
        .multiplicand_o(multiplicand_o), .multiplier_o(multiplier_o),
        .result_o(result_o), .result_valid_o(result_valid_o),
        .busy_o(busy_o), .done_o(done_o), .underrun_o(underrun_o),
        .fifo_level_o(fifo_level_o)
    );

    // Reference model: phases of a batch, a queue of pairs and plain integer counters.
    localparam int PH_IDLE = 0, PH_FEED = 1, PH_WAIT = 2, PH_DONE = 3;
    logic [9:0]  q[$];
    int          m_phase = PH_IDLE;
    int          m_issue = 0, m_res = 0;
    logic        m_upd_prev = 1'b0, m_underrun = 1'b0, m_rv = 1'b0;
    logic [15:0] m_result = 16'd0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit was_full, do_pop, starve, cap;
        if (reset_i) begin
            q.delete();
            m_phase = PH_IDLE; m_issue = 0; m_res = 0;
            m_upd_prev = 1'b0; m_underrun = 1'b0; m_rv = 1'b0; m_result = 16'd0;
            return;
        end
        was_full = (q.size() == 4);
        do_pop   = (m_phase == PH_FEED) && fetching_input_i && (q.size() > 0);
        starve   = (m_phase == PH_FEED) && fetching_input_i && (q.size() == 0);
        cap      = updating_acc_result_i && !m_upd_prev && (m_phase == PH_FEED || m_phase == PH_WAIT);
        m_rv = cap;
        if (cap) m_result = mac_result_i;
        if (cap && m_res > 0) m_res--;
        if (starve) m_underrun = 1'b1;
        case (m_phase)
            PH_IDLE: if (start_i && batch_len_i != 4'd0) begin
                m_phase = PH_FEED; m_issue = int'(batch_len_i); m_res = int'(batch_len_i);
                m_underrun = 1'b0;
            end
            PH_FEED: if (do_pop) begin
                m_issue--;
                if (m_issue == 0) m_phase = PH_WAIT;
            end
            PH_WAIT: if (m_res == 0) m_phase = PH_DONE;
            default: m_phase = PH_IDLE;
        endcase
        if (do_pop) void'(q.pop_front());
        if (!was_full && wr_valid_i) q.push_back({wr_multiplicand_i, wr_multiplier_i});
        m_upd_prev = updating_acc_result_i;
    endtask

    task automatic compare_all();
        logic [9:0] exp_ops;
        exp_ops = (m_phase == PH_FEED && q.size() > 0) ? q[0] : 10'd0;
        chk("operands", {6'd0, multiplicand_o, multiplier_o}, {6'd0, exp_ops});
        chk("fifo_level", {13'd0, fifo_level_o}, 16'(q.size()));
        chk("wr_ready", {15'd0, wr_ready_o}, {15'd0, q.size() < 4});
        chk("busy", {15'd0, busy_o}, {15'd0, m_phase != PH_IDLE});
        chk("done", {15'd0, done_o}, {15'd0, m_phase == PH_DONE});
        chk("underrun", {15'd0, underrun_o}, {15'd0, m_underrun});
        chk("result_valid", {15'd0, result_valid_o}, {15'd0, m_rv});
        chk("result", result_o, m_result);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic push_pair(input logic [4:0] a, input logic [4:0] b);
        wr_valid_i = 1'b1; wr_multiplicand_i = a; wr_multiplier_i = b;
        cyc();
        wr_valid_i = 1'b0;
    endtask

    task automatic result_pulse(input logic [15:0] val);
        updating_acc_result_i = 1'b1; mac_result_i = val;
        cyc();
        updating_acc_result_i = 1'b0;
        cyc();
    endtask

    initial begin
        reset_i = 1'b1; wr_valid_i = 1'b0; wr_multiplicand_i = '0; wr_multiplier_i = '0;
        start_i = 1'b0; batch_len_i = '0; fetching_input_i = 1'b0;
        updating_acc_result_i = 1'b0; mac_result_i = '0;
        cyc(); cyc();
        reset_i = 1'b0;
        chk("rst_level", {13'd0, fifo_level_o}, 16'd0);
        chk("rst_ready", {15'd0, wr_ready_o}, 16'd1);
        chk("rst_busy", {15'd0, busy_o}, 16'd0);

        // Zero-length start is ignored.
        start_i = 1'b1; batch_len_i = 4'd0;
        cyc();
        start_i = 1'b0;
        chk("len0_ignored", {15'd0, busy_o}, 16'd0);

        // Two-pair batch: operands 3/4 then 5/6, level 2->1->0.
        push_pair(5'd3, 5'd4);
        push_pair(5'd5, 5'd6);
        chk("b1_level2", {13'd0, fifo_level_o}, 16'd2);
        start_i = 1'b1; batch_len_i = 4'd2;
        cyc();
        start_i = 1'b0;
        chk("b1_head34", {6'd0, multiplicand_o, multiplier_o}, {6'd0, 5'd3, 5'd4});
        fetching_input_i = 1'b1;
        cyc();
        chk("b1_head56", {6'd0, multiplicand_o, multiplier_o}, {6'd0, 5'd5, 5'd6});
        chk("b1_level1", {13'd0, fifo_level_o}, 16'd1);
        cyc();
        fetching_input_i = 1'b0;
        chk("b1_level0", {13'd0, fifo_level_o}, 16'd0);

        // Held update strobe yields a single capture.
        updating_acc_result_i = 1'b1; mac_result_i = 16'h000C;
        cyc();
        chk("cap1_valid", {15'd0, result_valid_o}, 16'd1);
        chk("cap1_value", result_o, 16'h000C);
        cyc();
        chk("cap1_one_pulse", {15'd0, result_valid_o}, 16'd0);
        updating_acc_result_i = 1'b0;
        cyc();
        updating_acc_result_i = 1'b1; mac_result_i = 16'h002A;
        cyc();
        updating_acc_result_i = 1'b0;
        chk("cap2_value", result_o, 16'h002A);
        chk("b1_done", {15'd0, done_o}, 16'd1);
        cyc();
        chk("b1_done_clear", {15'd0, done_o}, 16'd0);
        chk("b1_idle", {15'd0, busy_o}, 16'd0);

        // Underrun on empty FIFO, then recovery.
        start_i = 1'b1; batch_len_i = 4'd1;
        cyc();
        start_i = 1'b0; fetching_input_i = 1'b1;
        cyc();
        fetching_input_i = 1'b0;
        chk("ur_flag", {15'd0, underrun_o}, 16'd1);
        chk("ur_ops_zero", {6'd0, multiplicand_o, multiplier_o}, 16'd0);
        chk("ur_still_busy", {15'd0, busy_o}, 16'd1);
        wr_valid_i = 1'b1; wr_multiplicand_i = 5'd9; wr_multiplier_i = 5'd9;
        #1;
        chk("push_not_visible", {6'd0, multiplicand_o, multiplier_o}, 16'd0);
        cyc();
        wr_valid_i = 1'b0;
        chk("push_visible", {6'd0, multiplicand_o, multiplier_o}, {6'd0, 5'd9, 5'd9});
        fetching_input_i = 1'b1;
        cyc();
        fetching_input_i = 1'b0;
        chk("ur_pop_level", {13'd0, fifo_level_o}, 16'd0);
        result_pulse(16'h1234);
        cyc();
        chk("ur_sticky", {15'd0, underrun_o}, 16'd1);

        // Fill past full, then push+pop at full and at level 3.
        for (int i = 1; i <= 5; i++) push_pair(5'(i), 5'(i));
        chk("full_level", {13'd0, fifo_level_o}, 16'd4);
        chk("full_not_ready", {15'd0, wr_ready_o}, 16'd0);
        start_i = 1'b1; batch_len_i = 4'd4;
        cyc();
        start_i = 1'b0;
        chk("ur_cleared", {15'd0, underrun_o}, 16'd0);
        wr_valid_i = 1'b1; wr_multiplicand_i = 5'd7; wr_multiplier_i = 5'd7; fetching_input_i = 1'b1;
        cyc();
        chk("full_pushpop_dropped", {13'd0, fifo_level_o}, 16'd3);
        wr_multiplicand_i = 5'd8; wr_multiplier_i = 5'd8;
        cyc();
        wr_valid_i = 1'b0;
        chk("pushpop_holds", {13'd0, fifo_level_o}, 16'd3);
        chk("head33", {6'd0, multiplicand_o, multiplier_o}, {6'd0, 5'd3, 5'd3});
        cyc(); cyc();
        fetching_input_i = 1'b0;
        for (int i = 0; i < 4; i++) result_pulse(16'(i * 3 + 1));
        cyc();
        chk("b2_idle", {15'd0, busy_o}, 16'd0);

        // Mid-batch reset with two entries queued.
        push_pair(5'd2, 5'd2);
        start_i = 1'b1; batch_len_i = 4'd3;
        cyc();
        start_i = 1'b0;
        chk("pre_rst_level", {13'd0, fifo_level_o}, 16'd2);
        reset_i = 1'b1;
        cyc();
        reset_i = 1'b0;
        chk("mid_rst_level", {13'd0, fifo_level_o}, 16'd0);
        chk("mid_rst_busy", {15'd0, busy_o}, 16'd0);
        chk("mid_rst_result", result_o, 16'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset_i               = ($urandom_range(0, 199) == 0);
            wr_valid_i            = 1'($urandom_range(0, 1));
            wr_multiplicand_i     = 5'($urandom_range(0, 31));
            wr_multiplier_i       = 5'($urandom_range(0, 31));
            start_i               = ($urandom_range(0, 5) == 0);
            batch_len_i           = 4'($urandom_range(0, 15));
            fetching_input_i      = 1'($urandom_range(0, 1));
            updating_acc_result_i = ($urandom_range(0, 2) == 0);
            mac_result_i          = 16'($urandom_range(0, 65535));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
